// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter granting a registered single-port RAM to three request/ack clients
module ram_port_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              req_3,
    input  logic              we_1,
    input  logic              we_2,
    input  logic              we_3,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [ADDR_W-1:0] addr_3,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic [DATA_W-1:0] wdata_3,
    output logic              ack_1,
    output logic              ack_2,
    output logic              ack_3,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    output logic [DATA_W-1:0] rdata_3,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        grant,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d, last_q, last_d, winner;
    logic [2:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d, wren_q, wren_d;
    logic [3:1]        req_v, ack_q, ack_d, grant_oh;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, rdata3_q, rdata3_d;

    assign req_v = {req_3, req_2, req_1};

    // Search starts at the client after the last winner, wrapping 3 -> 1.
    always_comb begin
        winner = 2'd0;
        case (last_q)
            2'd1: begin
                if (req_v[2])      winner = 2'd2;
                else if (req_v[3]) winner = 2'd3;
                else if (req_v[1]) winner = 2'd1;
            end
            2'd2: begin
                if (req_v[3])      winner = 2'd3;
                else if (req_v[1]) winner = 2'd1;
                else if (req_v[2]) winner = 2'd2;
            end
            default: begin
                if (req_v[1])      winner = 2'd1;
                else if (req_v[2]) winner = 2'd2;
                else if (req_v[3]) winner = 2'd3;
            end
        endcase
    end

    always_comb begin
        case (grant_q)
            2'd1:    grant_oh = 3'b001;
            2'd2:    grant_oh = 3'b010;
            2'd3:    grant_oh = 3'b100;
            default: grant_oh = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (winner != 2'd0) state_d = ISSUE;
            ISSUE:   state_d = wren_q ? ACK : WAIT;
            WAIT:    if (cnt_q == 3'd1) state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        ack_d    = 3'b000;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rdata3_d = rdata3_q;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                grant_d = winner;
                if (winner != 2'd0) last_d = winner;
                case (winner)
                    2'd1:    begin addr_d = addr_1; data_d = wdata_1; wren_d = we_1; end
                    2'd2:    begin addr_d = addr_2; data_d = wdata_2; wren_d = we_2; end
                    2'd3:    begin addr_d = addr_3; data_d = wdata_3; wren_d = we_3; end
                    default: ;
                endcase
            end
            ISSUE: begin
                if (wren_q) ack_d = grant_oh;
                else        cnt_d = LAT;
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    ack_d = grant_oh;
                    if (grant_q == 2'd1) rdata1_d = ram_q;
                    if (grant_q == 2'd2) rdata2_d = ram_q;
                    if (grant_q == 2'd3) rdata3_d = ram_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: grant_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
            wren_q   <= 1'b0;
            ack_q    <= 3'b000;
            addr_q   <= '0;
            data_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rdata3_q <= '0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wren_q   <= wren_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rdata3_q <= rdata3_d;
        end
    end

    assign ack_1       = ack_q[1];
    assign ack_2       = ack_q[2];
    assign ack_3       = ack_q[3];
    assign rdata_1     = rdata1_q;
    assign rdata_2     = rdata2_q;
    assign rdata_3     = rdata3_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
endmodule
